// File: rtl/imem_line_responder_pkg.sv
// Shared types and constants for the instruction-memory line responder.
package imem_line_responder_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StFill,
      StResp
   } imem_rsp_state_t;

   localparam int unsigned LINE_BYTES   = 32;
   localparam int unsigned TAG_LSB      = 5;
   localparam int unsigned WORD_SEL_MSB = 4;
   localparam int unsigned TAG_WIDTH    = 32 - TAG_LSB;

   // Words are little-endian within a 64-bit beat.
   function automatic logic [31:0] beat_word(input logic [63:0] beat, input logic hi);
      return hi ? beat[63:32] : beat[31:0];
   endfunction

endpackage

// File: rtl/imem_line_responder_if.sv
// Fetch-side imem request bus plus the bmem burst-read bus of the line responder.
interface imem_line_responder_if;

   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic        inv;

   logic [31:0] bmem_addr;
   logic        bmem_read;
   logic        bmem_ready;
   logic [63:0] bmem_rdata;
   logic        bmem_rvalid;

   modport slave (
      input  imem_addr,
      input  imem_rmask,
      input  inv,
      input  bmem_ready,
      input  bmem_rdata,
      input  bmem_rvalid,
      output imem_rdata,
      output imem_resp,
      output bmem_addr,
      output bmem_read
   );

   modport master (
      output imem_addr,
      output imem_rmask,
      output inv,
      output bmem_ready,
      output bmem_rdata,
      output bmem_rvalid,
      input  imem_rdata,
      input  imem_resp,
      input  bmem_addr,
      input  bmem_read
   );

endinterface

// File: rtl/imem_line_responder_line_buffer.sv
// Single-line buffer: beat storage with a beat write port, valid/tag, and a word read mux.
module imem_line_responder_line_buffer
   import imem_line_responder_pkg::*;
#(
   parameter int unsigned BEAT_WIDTH = 64,
   parameter int unsigned LINE_BEATS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  beat_we,
   input  logic [1:0]            beat_idx,
   input  logic [BEAT_WIDTH-1:0] beat_data,
   input  logic                  set_valid,
   input  logic                  clr_valid,
   input  logic                  tag_we,
   input  logic [TAG_WIDTH-1:0]  tag_in,
   input  logic [2:0]            word_sel,
   output logic [31:0]           word,
   output logic                  valid,
   output logic [TAG_WIDTH-1:0]  tag
);

   logic [BEAT_WIDTH-1:0] beats_q [LINE_BEATS];
   logic                  valid_q;
   logic [TAG_WIDTH-1:0]  tag_q;

   // Data needs no reset: it is only read while valid or right after a complete fill.
   always_ff @(posedge clk) begin
      if (beat_we) begin
         beats_q[beat_idx] <= beat_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else begin
         if (tag_we) begin
            tag_q <= tag_in;
         end
         if (clr_valid) begin
            valid_q <= 1'b0;
         end else if (set_valid) begin
            valid_q <= 1'b1;
         end
      end
   end

   assign word  = beat_word(beats_q[word_sel[2:1]], word_sel[0]);
   assign valid = valid_q;
   assign tag   = tag_q;

endmodule

// File: rtl/imem_line_responder.sv
// Instruction-memory responder: serves fetch reads from one 32-byte line, refilling it from bmem
// with a 4-beat burst on a miss.
module imem_line_responder
   import imem_line_responder_pkg::*;
#(
   parameter int unsigned BEAT_WIDTH = 64,
   parameter int unsigned LINE_BEATS = 4
) (
   input logic                  clk,
   input logic                  rst,
   imem_line_responder_if.slave bus
);

   imem_rsp_state_t state_q;
   logic [1:0]      beat_cnt_q;
   logic [2:0]      word_sel_q;
   logic            inv_seen_q;
   logic [31:0]     bmem_addr_q;
   logic            bmem_read_q;
   logic            imem_resp_q;
   logic [31:0]     imem_rdata_q;

   logic                 req;
   logic                 hit;
   logic                 beat_we;
   logic                 last_beat;
   logic                 set_valid;
   logic                 clr_valid;
   logic                 buf_valid;
   logic [TAG_WIDTH-1:0] buf_tag;
   logic [2:0]           rd_sel;
   logic [31:0]          buf_word;
   logic [31:0]          fill_word;
   logic                 unused_addr_bits;

   assign unused_addr_bits = ^bus.imem_addr[1:0];

   assign req       = |bus.imem_rmask;
   assign hit       = buf_valid && (buf_tag == bus.imem_addr[31:TAG_LSB]) && !bus.inv;
   assign beat_we   = (state_q == StFill) && bus.bmem_rvalid;
   assign last_beat = beat_we && (beat_cnt_q == 2'd3);

   // An inv seen at any point of the fill keeps the freshly filled line invalid.
   assign set_valid = last_beat && !inv_seen_q && !bus.inv;
   assign clr_valid = (((state_q == StIdle) || (state_q == StResp)) && bus.inv) ||
                      ((state_q == StIdle) && req && !hit);

   // Hits index with the live address; a fill returns the word latched at miss time.
   assign rd_sel = (state_q == StIdle) ? bus.imem_addr[WORD_SEL_MSB:2] : word_sel_q;

   // The last beat is still in flight when the response is registered, so bypass it.
   assign fill_word = (word_sel_q[2:1] == 2'd3) ? beat_word(bus.bmem_rdata, word_sel_q[0])
                                                : buf_word;

   imem_line_responder_line_buffer #(
      .BEAT_WIDTH(BEAT_WIDTH),
      .LINE_BEATS(LINE_BEATS)
   ) u_line_buffer (
      .clk       (clk),
      .rst       (rst),
      .beat_we   (beat_we),
      .beat_idx  (beat_cnt_q),
      .beat_data (bus.bmem_rdata),
      .set_valid (set_valid),
      .clr_valid (clr_valid),
      .tag_we    (last_beat),
      .tag_in    (bmem_addr_q[31:TAG_LSB]),
      .word_sel  (rd_sel),
      .word      (buf_word),
      .valid     (buf_valid),
      .tag       (buf_tag)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         beat_cnt_q   <= '0;
         word_sel_q   <= '0;
         inv_seen_q   <= 1'b0;
         bmem_addr_q  <= '0;
         bmem_read_q  <= 1'b0;
         imem_resp_q  <= 1'b0;
         imem_rdata_q <= '0;
      end else begin
         imem_resp_q  <= 1'b0;
         imem_rdata_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  if (hit) begin
                     imem_resp_q  <= 1'b1;
                     imem_rdata_q <= buf_word;
                     state_q      <= StResp;
                  end else begin
                     bmem_addr_q <= {bus.imem_addr[31:TAG_LSB], {TAG_LSB{1'b0}}};
                     bmem_read_q <= 1'b1;
                     word_sel_q  <= bus.imem_addr[WORD_SEL_MSB:2];
                     inv_seen_q  <= 1'b0;
                     state_q     <= StReq;
                  end
               end
            end
            StReq: begin
               if (bus.inv) begin
                  inv_seen_q <= 1'b1;
               end
               if (bus.bmem_ready) begin
                  bmem_read_q <= 1'b0;
                  beat_cnt_q  <= '0;
                  state_q     <= StFill;
               end
            end
            StFill: begin
               if (bus.inv) begin
                  inv_seen_q <= 1'b1;
               end
               if (bus.bmem_rvalid) begin
                  beat_cnt_q <= beat_cnt_q + 2'd1;
                  if (beat_cnt_q == 2'd3) begin
                     imem_resp_q  <= 1'b1;
                     imem_rdata_q <= fill_word;
                     state_q      <= StResp;
                  end
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.imem_resp  = imem_resp_q;
   assign bus.imem_rdata = imem_rdata_q;
   assign bus.bmem_read  = bmem_read_q;
   assign bus.bmem_addr  = bmem_addr_q;

endmodule

// File: tb/tb_imem_line_responder.sv
// Bench for imem_line_responder: a bmem model serves bursts from a sparse memory, and a
// line-level cache model predicts hit/miss, data and latency.
module tb_imem_line_responder;

   logic clk;
   logic rst;
   imem_line_responder_if bus ();

   imem_line_responder #(
      .BEAT_WIDTH(64),
      .LINE_BEATS(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cycle = 0;
   always @(posedge clk) cycle++;

   int n_cmp = 0;
   int n_bad = 0;

   // Backing memory, keyed by 8-byte-aligned beat address.
   logic [63:0] mem [logic [31:0]];

   function automatic logic [63:0] mem_beat(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
      return mem[a];
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [63:0] b;
      b = mem_beat({a[31:3], 3'b000});
      return a[2] ? b[63:32] : b[31:0];
   endfunction

   // Line-level reference: one valid line with its tag.
   bit          m_valid = 1'b0;
   logic [26:0] m_tag   = '0;

   // inv_lat is the cycle offset after the request at which inv pulses (0 = with the request).
   // A hit ends one cycle after the request, so only inv_lat <= 1 reaches it; a miss lasts at
   // least six cycles, so any inv_lat in 1..5 lands in REQ/FILL.
   function automatic bit model_access(input logic [31:0] a, input int inv_lat);
      bit h;
      if (inv_lat == 0) m_valid = 1'b0;
      h = m_valid && (m_tag == a[31:5]);
      if (!h) begin
         m_tag   = a[31:5];
         m_valid = 1'b1;
      end
      if (inv_lat >= 1 && (!h || inv_lat <= 1)) m_valid = 1'b0;
      return h;
   endfunction

   // bmem model controls and observations
   int          ready_delay = 0;
   int          gap_mode    = 0;
   int          beat_limit  = 4;
   int          stray_beats = 0;
   int          bmem_reqs   = 0;
   int          bmem_errs   = 0;
   int          beats_sent  = 0;
   int          last_beat_cycle = 0;
   bit          pend_hs = 0;
   bit          filling = 0;
   bit          read_prev = 0;
   bit          gap_next = 0;
   bit          give = 0;
   int          wait_cnt = 0;
   logic [31:0] fill_base = '0;
   logic [31:0] addr_prev = '0;

   initial begin
      bus.bmem_ready  = 1'b0;
      bus.bmem_rvalid = 1'b0;
      bus.bmem_rdata  = '0;
      forever begin
         @(negedge clk);
         bus.bmem_ready  = 1'b0;
         bus.bmem_rvalid = 1'b0;
         if (rst === 1'b1) begin
            pend_hs   = 1'b0;
            filling   = 1'b0;
            wait_cnt  = 0;
            read_prev = 1'b0;
         end else if (stray_beats > 0) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = {$urandom, $urandom};
            stray_beats--;
         end else begin
            if (pend_hs) begin
               pend_hs    = 1'b0;
               filling    = 1'b1;
               beats_sent = 0;
               gap_next   = 1'b0;
               read_prev  = 1'b0;
               bmem_reqs++;
            end
            if (filling) begin
               if (bus.bmem_read === 1'b1) bmem_errs++;
               give = (beats_sent < beat_limit);
               if (give && gap_mode == 1 && gap_next) begin
                  give     = 1'b0;
                  gap_next = 1'b0;
               end else if (give && gap_mode == 2 && $urandom_range(0, 2) == 0) begin
                  give = 1'b0;
               end
               if (give) begin
                  bus.bmem_rvalid = 1'b1;
                  bus.bmem_rdata  = mem_beat(fill_base + 32'(8 * beats_sent));
                  beats_sent++;
                  last_beat_cycle = cycle;
                  gap_next = 1'b1;
                  if (beats_sent == 4) filling = 1'b0;
               end
            end else if (bus.bmem_read === 1'b1) begin
               if (read_prev && bus.bmem_addr !== addr_prev) bmem_errs++;
               read_prev = 1'b1;
               addr_prev = bus.bmem_addr;
               if (wait_cnt < ready_delay) begin
                  wait_cnt++;
               end else begin
                  bus.bmem_ready = 1'b1;
                  pend_hs   = 1'b1;
                  wait_cnt  = 0;
                  fill_base = bus.bmem_addr;
               end
            end else begin
               if (read_prev) bmem_errs++;
               read_prev = 1'b0;
            end
         end
      end
   end

   // Drives one request from a negedge and returns at the negedge after the response cycle.
   task automatic issue(input logic [31:0] a, input int inv_lat, output int lat,
                        output logic [31:0] data, output int nreq, output int first_read,
                        output logic [31:0] first_addr, output int resp_cycle);
      int start;
      start      = bmem_reqs;
      first_read = -1;
      first_addr = '0;
      bus.imem_addr  = a;
      bus.imem_rmask = 4'($urandom_range(1, 15));
      bus.inv        = (inv_lat == 0);
      lat = 0;
      while (bus.imem_resp !== 1'b1 && lat < 400) begin
         @(negedge clk);
         lat++;
         bus.inv = (lat == inv_lat);
         if (bus.bmem_read === 1'b1 && first_read < 0) begin
            first_read = lat;
            first_addr = bus.bmem_addr;
         end
      end
      data       = bus.imem_rdata;
      resp_cycle = cycle;
      if (bus.imem_resp !== 1'b1) lat = -1;
      bus.imem_rmask = '0;
      bus.inv        = 1'b0;
      @(negedge clk);
      nreq = bmem_reqs - start;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.imem_addr  = '0;
      bus.imem_rmask = '0;
      bus.inv        = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.imem_resp !== 1'b0) begin
         $display("FAIL reset_resp: got %b want 0", bus.imem_resp); n_bad++;
      end
      n_cmp++;
      if (bus.imem_rdata !== 32'h0) begin
         $display("FAIL reset_rdata: got %h want 0", bus.imem_rdata); n_bad++;
      end
      n_cmp++;
      if (bus.bmem_read !== 1'b0) begin
         $display("FAIL reset_bmem_read: got %b want 0", bus.bmem_read); n_bad++;
      end
      n_cmp++;
      if (bus.bmem_addr !== 32'h0) begin
         $display("FAIL reset_bmem_addr: got %h want 0", bus.bmem_addr); n_bad++;
      end
      rst = 1'b0;
      m_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_cold_miss();
      int lat, nreq, fr, rc;
      logic [31:0] d, fa;
      bit h;
      mem[32'h6000_0000] = 64'h1111_1111_0000_0013;
      h = model_access(32'h6000_0000, -1);
      issue(32'h6000_0000, -1, lat, d, nreq, fr, fa, rc);
      n_cmp++;
      if (fr !== 1 || fa !== 32'h6000_0000) begin
         $display("FAIL cold_bmem_req: got cycle %0d addr %h want cycle 1 addr 60000000", fr, fa);
         n_bad++;
      end
      n_cmp++;
      if (lat !== 6) begin
         $display("FAIL cold_latency: got %0d want 6", lat); n_bad++;
      end
      n_cmp++;
      if (d !== 32'h0000_0013) begin
         $display("FAIL cold_rdata: got %h want 00000013", d); n_bad++;
      end
      n_cmp++;
      if (nreq !== (h ? 0 : 1)) begin
         $display("FAIL cold_nreq: got %0d want 1", nreq); n_bad++;
      end
   endtask

   task automatic test_hit();
      int lat, nreq, fr, rc;
      logic [31:0] d, fa;
      bit h;
      h = model_access(32'h6000_0004, -1);
      issue(32'h6000_0004, -1, lat, d, nreq, fr, fa, rc);
      n_cmp++;
      if (lat !== 1) begin
         $display("FAIL hit_latency: got %0d want 1", lat); n_bad++;
      end
      n_cmp++;
      if (d !== 32'h1111_1111) begin
         $display("FAIL hit_rdata: got %h want 11111111", d); n_bad++;
      end
      n_cmp++;
      if (nreq !== (h ? 0 : 1) || fr !== -1) begin
         $display("FAIL hit_no_bmem: got %0d reqs (read at %0d) want 0", nreq, fr); n_bad++;
      end
   endtask

   task automatic test_line_cross();
      int lat, nreq, fr, rc;
      logic [31:0] d, fa;
      bit h;
      h = model_access(32'h6000_001C, -1);
      issue(32'h6000_001C, -1, lat, d, nreq, fr, fa, rc);
      n_cmp++;
      if (lat !== 1 || nreq !== (h ? 0 : 1) || d !== exp_word(32'h6000_001C)) begin
         $display("FAIL cross_word7: got lat %0d reqs %0d data %h want lat 1 reqs 0 data %h",
                  lat, nreq, d, exp_word(32'h6000_001C));
         n_bad++;
      end
      h = model_access(32'h6000_0020, -1);
      issue(32'h6000_0020, -1, lat, d, nreq, fr, fa, rc);
      n_cmp++;
      if (fa !== 32'h6000_0020 || nreq !== (h ? 0 : 1)) begin
         $display("FAIL cross_miss_addr: got addr %h reqs %0d want addr 60000020 reqs 1", fa, nreq);
         n_bad++;
      end
      n_cmp++;
      if (lat !== 6 || d !== exp_word(32'h6000_0020)) begin
         $display("FAIL cross_miss_resp: got lat %0d data %h want lat 6 data %h",
                  lat, d, exp_word(32'h6000_0020));
         n_bad++;
      end
   endtask

   task automatic test_backpressure();
      int lat, nreq, fr, rc, errs0;
      logic [31:0] d, fa;
      bit h;
      errs0 = bmem_errs;
      ready_delay = 3;
      gap_mode    = 1;
      h = model_access(32'h6000_0048, -1);
      issue(32'h6000_0048, -1, lat, d, nreq, fr, fa, rc);
      ready_delay = 0;
      gap_mode    = 0;
      // 1 (REQ) + 3 ready-low + 1 accept, then 4 beats with 3 gaps, then RESP
      n_cmp++;
      if (lat !== 12 || rc !== last_beat_cycle + 1) begin
         $display("FAIL bp_latency: got lat %0d resp cycle %0d want lat 12 resp cycle %0d",
                  lat, rc, last_beat_cycle + 1);
         n_bad++;
      end
      n_cmp++;
      if (d !== exp_word(32'h6000_0048) || nreq !== (h ? 0 : 1)) begin
         $display("FAIL bp_rdata: got %h reqs %0d want %h reqs 1", d, nreq,
                  exp_word(32'h6000_0048));
         n_bad++;
      end
      n_cmp++;
      if (bmem_errs !== errs0) begin
         $display("FAIL bp_read_hold: got %0d bmem protocol errors want 0", bmem_errs - errs0);
         n_bad++;
      end
   endtask

   task automatic test_inv();
      int lat, nreq, fr, rc;
      logic [31:0] d, fa;
      bit h;
      bus.inv = 1'b1;
      @(negedge clk);
      bus.inv = 1'b0;
      m_valid = 1'b0;
      h = model_access(32'h6000_0044, -1);
      issue(32'h6000_0044, -1, lat, d, nreq, fr, fa, rc);
      n_cmp++;
      if (nreq !== 1 || d !== exp_word(32'h6000_0044)) begin
         $display("FAIL inv_idle_refetch: got reqs %0d data %h want reqs 1 data %h",
                  nreq, d, exp_word(32'h6000_0044));
         n_bad++;
      end
      h = model_access(32'h6000_0108, 3);
      issue(32'h6000_0108, 3, lat, d, nreq, fr, fa, rc);
      n_cmp++;
      if (lat !== 6 || nreq !== (h ? 0 : 1) || d !== exp_word(32'h6000_0108)) begin
         $display("FAIL inv_fill_resp: got lat %0d reqs %0d data %h want lat 6 reqs 1 data %h",
                  lat, nreq, d, exp_word(32'h6000_0108));
         n_bad++;
      end
      h = model_access(32'h6000_0104, -1);
      issue(32'h6000_0104, -1, lat, d, nreq, fr, fa, rc);
      n_cmp++;
      if (nreq !== (h ? 0 : 1) || nreq !== 1 || d !== exp_word(32'h6000_0104)) begin
         $display("FAIL inv_fill_remiss: got reqs %0d data %h want reqs 1 data %h",
                  nreq, d, exp_word(32'h6000_0104));
         n_bad++;
      end
      h = model_access(32'h6000_010C, 0);
      issue(32'h6000_010C, 0, lat, d, nreq, fr, fa, rc);
      n_cmp++;
      if (nreq !== (h ? 0 : 1) || d !== exp_word(32'h6000_010C)) begin
         $display("FAIL inv_with_req: got reqs %0d data %h want reqs 1 data %h",
                  nreq, d, exp_word(32'h6000_010C));
         n_bad++;
      end
   endtask

   task automatic test_reset_mid_fill();
      int lat, nreq, fr, rc, start, waited, resp_seen, read_seen;
      logic [31:0] d, fa;
      bit h;
      beat_limit = 2;
      start      = bmem_reqs;
      waited     = 0;
      resp_seen  = 0;
      read_seen  = 0;
      bus.imem_addr  = 32'h6000_0200;
      bus.imem_rmask = 4'hF;
      while (!(bmem_reqs > start && beats_sent == 2) && waited < 60) begin
         @(negedge clk);
         waited++;
         if (bus.imem_resp === 1'b1) resp_seen++;
      end
      n_cmp++;
      if (waited >= 60) begin
         $display("FAIL midfill_timeout: got no 2-beat fill within %0d cycles want one", waited);
         n_bad++;
      end
      @(negedge clk);
      rst = 1'b1;
      bus.imem_rmask = '0;
      repeat (2) begin
         @(negedge clk);
         if (bus.imem_resp === 1'b1) resp_seen++;
      end
      n_cmp++;
      if (bus.bmem_addr !== 32'h0) begin
         $display("FAIL midfill_reset_addr: got %h want 0", bus.bmem_addr); n_bad++;
      end
      rst = 1'b0;
      beat_limit  = 4;
      stray_beats = 2;
      repeat (5) begin
         @(negedge clk);
         if (bus.imem_resp === 1'b1) resp_seen++;
         if (bus.bmem_read === 1'b1) read_seen++;
      end
      n_cmp++;
      if (resp_seen !== 0 || read_seen !== 0) begin
         $display("FAIL midfill_quiet: got %0d resp %0d read cycles want 0 0", resp_seen, read_seen);
         n_bad++;
      end
      m_valid = 1'b0;
      h = model_access(32'h6000_0204, -1);
      issue(32'h6000_0204, -1, lat, d, nreq, fr, fa, rc);
      n_cmp++;
      if (nreq !== (h ? 0 : 1) || lat !== 6 || d !== exp_word(32'h6000_0204)) begin
         $display("FAIL midfill_remiss: got reqs %0d lat %0d data %h want reqs 1 lat 6 data %h",
                  nreq, lat, d, exp_word(32'h6000_0204));
         n_bad++;
      end
   endtask

   task automatic test_random();
      int lat, nreq, fr, rc, r, inv_lat, errs0;
      logic [31:0] d, fa, a;
      logic [31:0] lines [3];
      bit h;
      lines[0] = 32'h6000_0000;
      lines[1] = 32'h6000_0020;
      lines[2] = 32'h7000_0100;
      errs0    = bmem_errs;
      gap_mode = 2;
      for (int i = 0; i < 40; i++) begin
         a = lines[$urandom_range(0, 2)] + 32'(4 * $urandom_range(0, 7));
         ready_delay = $urandom_range(0, 2);
         r = $urandom_range(0, 9);
         inv_lat = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 3 : -1;
         h = model_access(a, inv_lat);
         issue(a, inv_lat, lat, d, nreq, fr, fa, rc);
         n_cmp++;
         if (h && (lat !== 1 || nreq !== 0)) begin
            $display("FAIL rand_hit[%0d]: addr %h got lat %0d reqs %0d want lat 1 reqs 0",
                     i, a, lat, nreq);
            n_bad++;
         end else if (!h && (nreq !== 1 || fa !== {a[31:5], 5'b0} ||
                             rc !== last_beat_cycle + 1)) begin
            $display("FAIL rand_miss[%0d]: addr %h got reqs %0d bmem %h resp %0d want 1 %h %0d",
                     i, a, nreq, fa, rc, {a[31:5], 5'b0}, last_beat_cycle + 1);
            n_bad++;
         end
         n_cmp++;
         if (d !== exp_word(a)) begin
            $display("FAIL rand_rdata[%0d]: addr %h got %h want %h", i, a, d, exp_word(a));
            n_bad++;
         end
      end
      gap_mode    = 0;
      ready_delay = 0;
      n_cmp++;
      if (bmem_errs !== errs0) begin
         $display("FAIL rand_bmem_protocol: got %0d errors want 0", bmem_errs - errs0);
         n_bad++;
      end
   endtask

   initial begin
      rst            = 1'b1;
      bus.imem_addr  = '0;
      bus.imem_rmask = '0;
      bus.inv        = 1'b0;
      test_reset();
      test_cold_miss();
      test_hit();
      test_line_cross();
      test_backpressure();
      test_inv();
      test_reset_mid_fill();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_line_responder.md
Name: imem_line_responder

Overview:
- Instruction-memory responder serving the fetch stage's imem request interface (imem_addr, imem_rmask, imem_rdata, imem_resp).
- Holds a single 32-byte line buffer. A hit returns the word on the next cycle.
- A miss issues one burst read to backing memory (bmem), collects 4 x 64-bit beats, fills the buffer, then responds.
- Sits between the IF stage and the memory model / arbiter.

Parameters:
- BEAT_WIDTH, 64, bmem data beat width in bits; only 64 supported.
- LINE_BEATS, 4, beats per line; only 4 supported; line = 256 bits, 8 words.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- imem_addr  input  32  fetch byte address; bits[1:0] ignored
- imem_rmask  input  4  request valid when non-zero; any non-zero value = full-word read
- imem_rdata  output  32  fetched word, valid only while imem_resp=1
- imem_resp  output  1  one-cycle response pulse
- inv  input  1  invalidate line buffer (fence.i), single-cycle pulse
- bmem_addr  output  32  line-aligned burst address (bits[4:0]=0)
- bmem_read  output  1  burst read request, held until accepted
- bmem_ready  input  1  bmem accepts request when bmem_read & bmem_ready
- bmem_rdata  input  64  beat data
- bmem_rvalid  input  1  beat valid; beats arrive in address order, may have gaps

Behaviour:
- Reset values:
  - imem_resp=0, imem_rdata=0, bmem_read=0, bmem_addr=0.
  - line valid=0, tag=0, beat counter=0, state=IDLE.
- Requestor contract: holds imem_addr/imem_rmask stable from request until the cycle imem_resp=1. Next request may appear in the cycle after resp.
- States: IDLE, REQ, FILL, RESP.
- IDLE:
  - Samples the request when rmask!=0.
  - Hit (valid & tag==addr[31:5] & !inv): latch word addr[4:2] and go to RESP. Resp comes exactly 1 cycle after the request cycle.
  - Miss: latch bmem_addr={addr[31:5],5'b0}, clear valid, go to REQ.
  - Request is not sampled in the RESP cycle; throughput on hits is one request per 2 cycles.
- REQ:
  - bmem_read=1.
  - On bmem_ready: drop bmem_read in the next cycle, reset the beat counter, go to FILL.
- FILL:
  - Each bmem_rvalid writes bmem_rdata into beat slot[counter] and increments counter (2-bit).
  - On the beat with counter==3: set valid=1, tag=bmem_addr[31:5], go to RESP.
  - Minimum miss latency: request cycle + 1 (REQ, ready=1) + 4 beats + 1 (RESP) = resp 6 cycles after the request cycle.
- RESP:
  - imem_resp=1.
  - imem_rdata = word[addr[4:2]] of the buffer: word k = beat[k>>1] bits[32*(k&1) +: 32], i.e. little-endian within the beat.
  - Next state IDLE.
- inv:
  - In IDLE or RESP, clears valid next edge; inv coincident with a request forces a miss.
  - In REQ/FILL: fill completes and the response is delivered with the filled data, but valid is left 0 at fill end.
- bmem_rvalid outside FILL is ignored. Stray beats after reset are dropped.
- Reset mid-fill: all state returns to reset values; no response is issued for the interrupted request.
- Words within one line never issue a bmem read once the line is valid.

Decomposition:
- Shared package (rv32i_types or imem pkg):
  - state enum imem_rsp_state_t {IDLE, REQ, FILL, RESP}.
  - Constants LINE_BYTES=32, TAG_LSB=5, WORD_SEL_MSB=4.
- Sub-module line_buffer: 4 x 64-bit storage plus valid/tag, beat write port, word read mux. The FSM stays in the top module.

Test Plan:
- Cold miss: after reset, rmask=4'hF, addr=0x6000_0000; bmem_ready=1, beats 0x1111_1111_0000_0013, then 3 more, back-to-back.
  -> bmem_read asserted with bmem_addr=0x6000_0000 one cycle after the request.
  -> imem_resp at request+6 with rdata=0x0000_0013.
- Hit: follow-up request addr=0x6000_0004 -> resp next cycle, rdata=0x1111_1111, no bmem_read.
- Line crossing: addr=0x6000_001C hits word 7; then addr=0x6000_0020 -> miss, bmem_addr=0x6000_0020.
- Gapped beats/backpressure: bmem_ready low 3 cycles, rvalid with 1-cycle gaps between beats -> bmem_read held stable; resp only after the 4th beat; data correct.
- inv: inv pulse in IDLE, then request to the cached line -> miss refetch. inv during FILL -> resp still delivered, next same-line request misses.
- Reset mid-fill: assert rst after beat 2, deassert, supply 2 stray rvalid beats -> no imem_resp, valid=0, next request misses.
